smm_tile_sequencer: RTL and testbench

- Initiator side of the 2x2 Strassen multiplier interface. Drives the A/B operand buses, load and sel, and collects the packed C result.
- Accepts one 4x4 A and one 4x4 B per transaction and issues the 8 block products C_IJ += A_IK * B_KJ to the 2x2 multiplier, pipelined at one product per cycle.
- Accumulates the 8 returned tiles into a 4x4 result and presents it on a valid/ready output.

---
 rtl/smm_pkg.sv | 29 ++
 rtl/smm_tile_accum.sv | 68 ++++++
 rtl/smm_tile_sequencer.sv | 155 +++++++++++++++
 tb/tb_smm_tile_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smm_pkg.sv
// Shared types and helpers for the 4x4 tile sequencer driving a 2x2 Strassen multiplier.
// Element index of slot s in tile (ti,tj) is {ti, s[1], tj, s[0]} = 4*(2ti+s1) + 2tj+s0.
package smm_pkg;

   localparam int DATAWIDTH_DEFAULT = 32;
   localparam int SMM_LAT_DEFAULT   = 2;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   typedef struct packed {
      logic i;
      logic j;
      logic k;
   } pdec_t;

   function automatic pdec_t p_decode(input logic [2:0] p);
      pdec_t d;
      d.i = p[2];
      d.j = p[1];
      d.k = p[0];
      return d;
   endfunction

   // Matrix element index for tile slot; multiply by the element width for the bit slice.
   function automatic logic [3:0] tile_elem(input logic ti, input logic tj, input logic [1:0] slot);
      return {ti, slot[1], tj, slot[0]};
   endfunction

endpackage

// File: rtl/smm_tile_accum.sv
// Four 2x2 accumulator tiles forming the 4x4 result; a tile is overwritten or added to.
// With SMM_SAT_ACC_EN defined the add saturates and reports each saturating update.
module smm_tile_accum
   import smm_pkg::*;
#(
   parameter int DATAWIDTH = DATAWIDTH_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    upd,
   input  logic                    ti,
   input  logic                    tj,
   input  logic                    add,
   input  logic [4*DATAWIDTH-1:0]  tile_in,
`ifdef SMM_SAT_ACC_EN
   output logic                    sat_hit,
`endif
   output logic [16*DATAWIDTH-1:0] acc
);
   localparam int DW = DATAWIDTH;

   logic [DW-1:0] acc_q [16];
   logic [DW-1:0] cur   [4];
   logic [DW-1:0] inc   [4];
   logic [DW-1:0] res   [4];
`ifdef SMM_SAT_ACC_EN
   logic [DW:0]   sum_ext [4];
   logic [3:0]    sat;
`endif

   always_comb begin
`ifdef SMM_SAT_ACC_EN
      sat = '0;
`endif
      for (int s = 0; s < 4; s++) begin
         cur[s] = acc_q[tile_elem(ti, tj, 2'(s))];
         inc[s] = tile_in[s*DW +: DW];
         res[s] = add ? cur[s] + inc[s] : inc[s];
`ifdef SMM_SAT_ACC_EN
         sum_ext[s] = {cur[s][DW-1], cur[s]} + {inc[s][DW-1], inc[s]};
         sat[s] = add && (sum_ext[s][DW] != sum_ext[s][DW-1]);
         if (sat[s])
            res[s] = sum_ext[s][DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
      end
   end

`ifdef SMM_SAT_ACC_EN
   assign sat_hit = upd && (|sat);
`endif

   always_comb begin
      acc = '0;
      for (int e = 0; e < 16; e++)
         acc[e*DW +: DW] = acc_q[e];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int e = 0; e < 16; e++)
            acc_q[e] <= '0;
      end else if (upd) begin
         for (int s = 0; s < 4; s++)
            acc_q[tile_elem(ti, tj, 2'(s))] <= res[s];
      end
   end

endmodule

// File: rtl/smm_tile_sequencer.sv
// Issues the 8 block products of a 4x4 x 4x4 multiply to a 2x2 multiplier and accumulates C.
// Optional SMM_SAT_ACC_EN: saturating accumulation with sticky acc_ovf output.
//
//   state | meaning
//   IDLE  | waiting for an A/B handshake; product 0 is issued on the handshake edge
//   ISSUE | smm_load high, one block product per cycle (8 cycles)
//   DRAIN | waiting for in-flight tags to retire into the accumulators
//   DONE  | c_mat held with out_valid until out_ready
module smm_tile_sequencer
   import smm_pkg::*;
#(
   parameter int DATAWIDTH = DATAWIDTH_DEFAULT,
   parameter int SMM_LAT   = SMM_LAT_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [16*DATAWIDTH-1:0] a_mat,
   input  logic [16*DATAWIDTH-1:0] b_mat,
   output logic [4*DATAWIDTH-1:0]  smm_a,
   output logic [4*DATAWIDTH-1:0]  smm_b,
   output logic                    smm_load,
   output logic                    smm_sel,
   input  logic [4*DATAWIDTH-1:0]  smm_c,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [16*DATAWIDTH-1:0] c_mat,
`ifdef SMM_SAT_ACC_EN
   output logic                    acc_ovf,
`endif
   output logic                    busy
);
   localparam int DW = DATAWIDTH;

   state_t                  state;
   logic [16*DW-1:0]        a_reg, b_reg;
   logic [16*DW-1:0]        src_a, src_b;
   logic [3:0]              p_cnt;
   logic [2:0]              p_issue;
   logic [SMM_LAT:0][3:0]   tag_pipe;
   pdec_t                   pd_issue, pd_exit;
   logic [4*DW-1:0]         tile_a, tile_b;
   logic                    accept, drain_empty, exit_vld;

   assign accept   = (state == IDLE) && in_valid && in_ready;
   assign smm_sel  = 1'b0;
   assign exit_vld = tag_pipe[SMM_LAT][3];
   assign pd_exit  = p_decode(tag_pipe[SMM_LAT][2:0]);

   always_comb begin
      src_a    = (state == IDLE) ? a_mat : a_reg;
      src_b    = (state == IDLE) ? b_mat : b_reg;
      p_issue  = (state == IDLE) ? 3'd0 : p_cnt[2:0];
      pd_issue = p_decode(p_issue);
      tile_a   = '0;
      tile_b   = '0;
      for (int s = 0; s < 4; s++) begin
         tile_a[s*DW +: DW] = src_a[tile_elem(pd_issue.i, pd_issue.k, 2'(s))*DW +: DW];
         tile_b[s*DW +: DW] = src_b[tile_elem(pd_issue.k, pd_issue.j, 2'(s))*DW +: DW];
      end
      // The last pipe stage retires this cycle, so only the earlier stages matter.
      drain_empty = 1'b1;
      for (int i = 0; i < SMM_LAT; i++)
         if (tag_pipe[i][3]) drain_empty = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         smm_load  <= 1'b0;
         smm_a     <= '0;
         smm_b     <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         p_cnt     <= '0;
         tag_pipe  <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
      end else begin
         tag_pipe <= {tag_pipe[SMM_LAT-1:0], 4'b0000};
         unique case (state)
            IDLE: begin
               if (accept) begin
                  a_reg       <= a_mat;
                  b_reg       <= b_mat;
                  smm_a       <= tile_a;
                  smm_b       <= tile_b;
                  smm_load    <= 1'b1;
                  tag_pipe[0] <= {1'b1, p_issue};
                  p_cnt       <= 4'd1;
                  in_ready    <= 1'b0;
                  busy        <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (p_cnt[3]) begin
                  smm_load <= 1'b0;
                  state    <= DRAIN;
               end else begin
                  smm_a       <= tile_a;
                  smm_b       <= tile_b;
                  tag_pipe[0] <= {1'b1, p_issue};
                  p_cnt       <= p_cnt + 4'd1;
               end
            end
            DRAIN: begin
               if (drain_empty) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SMM_SAT_ACC_EN
   logic sat_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         acc_ovf <= 1'b0;
      else if (accept)
         acc_ovf <= 1'b0;
      else if (sat_hit)
         acc_ovf <= 1'b1;
   end
`endif

   smm_tile_accum #(.DATAWIDTH(DW)) u_accum (
      .clk     (clk),
      .rst     (rst),
      .upd     (exit_vld),
      .ti      (pd_exit.i),
      .tj      (pd_exit.j),
      .add     (pd_exit.k),
      .tile_in (smm_c),
`ifdef SMM_SAT_ACC_EN
      .sat_hit (sat_hit),
`endif
      .acc     (c_mat)
   );

endmodule

// File: tb/tb_smm_tile_sequencer.sv
// Bench for smm_tile_sequencer with a behavioural 2x2 multiplier and a matrix-level reference model.
module tb_smm_tile_sequencer;
   localparam int DW  = 32;
   localparam int LAT = 2;

   typedef logic [16*DW-1:0] mat_t;
   typedef struct {
      mat_t a;
      mat_t b;
      mat_t c;
      bit   ovf;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   mat_t             a_mat, b_mat, c_mat;
   logic [4*DW-1:0]  smm_a, smm_b, smm_c, mul_s1;
   logic             smm_load, smm_sel;
   logic             out_valid, out_ready, busy;
`ifdef SMM_SAT_ACC_EN
   logic             acc_ovf;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int load_run = 0;
   int last_run = 0;
   int sel_bad  = 0;

   smm_tile_sequencer #(.DATAWIDTH(DW), .SMM_LAT(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_mat     (a_mat),
      .b_mat     (b_mat),
      .smm_a     (smm_a),
      .smm_b     (smm_b),
      .smm_load  (smm_load),
      .smm_sel   (smm_sel),
      .smm_c     (smm_c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c_mat     (c_mat),
`ifdef SMM_SAT_ACC_EN
      .acc_ovf   (acc_ovf),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // 2x2 multiplier: re-registers its product every cycle, LAT register stages.
   function automatic logic [4*DW-1:0] tile_mul(input logic [4*DW-1:0] x, input logic [4*DW-1:0] y);
      logic [4*DW-1:0] r;
      r = '0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++)
            r[(2*i+j)*DW +: DW] = x[(2*i)*DW +: DW] * y[j*DW +: DW]
                                + x[(2*i+1)*DW +: DW] * y[(2+j)*DW +: DW];
      return r;
   endfunction

   always @(posedge clk) begin
      mul_s1 <= tile_mul(smm_a, smm_b);
      smm_c  <= mul_s1;
   end

   always @(negedge clk) begin
      if (smm_sel !== 1'b0) sel_bad++;
      if (smm_load) load_run++;
      else if (load_run != 0) begin
         last_run = load_run;
         load_run = 0;
      end
   end

   function automatic logic [DW-1:0] el(input mat_t m, input int r, input int c);
      return m[(4*r+c)*DW +: DW];
   endfunction

   function automatic mat_t fill(input logic [DW-1:0] v);
      mat_t m;
      for (int e = 0; e < 16; e++) m[e*DW +: DW] = v;
      return m;
   endfunction

   function automatic mat_t ident();
      mat_t m;
      m = '0;
      for (int r = 0; r < 4; r++) m[(5*r)*DW +: DW] = DW'(1);
      return m;
   endfunction

   function automatic mat_t count16();
      mat_t m;
      for (int e = 0; e < 16; e++) m[e*DW +: DW] = DW'(e + 1);
      return m;
   endfunction

   // C = A*B computed as two half-sums per element: columns 0-1 of A (K=0) and 2-3 (K=1).
   function automatic void ref_model(input mat_t a, input mat_t b, output mat_t c, output bit ovf);
      logic [DW-1:0] t0, t1;
`ifdef SMM_SAT_ACC_EN
      longint s;
      longint mx = (longint'(1) << (DW-1)) - 1;
      longint mn = -(longint'(1) << (DW-1));
`endif
      ovf = 1'b0;
      c   = '0;
      for (int r = 0; r < 4; r++)
         for (int col = 0; col < 4; col++) begin
            t0 = el(a, r, 0) * el(b, 0, col) + el(a, r, 1) * el(b, 1, col);
            t1 = el(a, r, 2) * el(b, 2, col) + el(a, r, 3) * el(b, 3, col);
`ifdef SMM_SAT_ACC_EN
            s = longint'(signed'(t0)) + longint'(signed'(t1));
            if (s > mx) begin s = mx; ovf = 1'b1; end
            if (s < mn) begin s = mn; ovf = 1'b1; end
            c[(4*r+col)*DW +: DW] = s[DW-1:0];
`else
            c[(4*r+col)*DW +: DW] = t0 + t1;
`endif
         end
   endfunction

   task automatic chk_v(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic chk_m(input string nm, input mat_t act, input mat_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic start_txn(input mat_t a, input mat_t b);
      int n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk_v("in_ready_before_txn", int'(in_ready), 1);
      a_mat    = a;
      b_mat    = b;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic accept_out();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_v("out_valid_after_accept", int'(out_valid), 0);
   endtask

   task automatic run_txn(input mat_t a, input mat_t b, input mat_t exp_c, input bit exp_ovf, input int hold);
      int lat;
      out_ready = (hold == 0);
      start_txn(a, b);
      wait_out(lat);
      chk_v("latency", lat, 10);
      chk_m("c_mat", c_mat, exp_c);
`ifdef SMM_SAT_ACC_EN
      chk_v("acc_ovf", int'(acc_ovf), int'(exp_ovf));
`else
      chk_v("no_ovf_expected", int'(exp_ovf), int'(exp_ovf & 1'b0));
`endif
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk_v("hold_out_valid", int'(out_valid), 1);
         chk_m("hold_c_mat", c_mat, exp_c);
      end
      accept_out();
   endtask

   vec_t vecs[5];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int   lat, t1, t2;
      mat_t ra, rb, rc;
      bit   rovf;
      int   mode;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a_mat = '0; b_mat = '0;
      repeat (3) @(negedge clk);
      chk_v("rst_in_ready", int'(in_ready), 1);
      chk_v("rst_busy", int'(busy), 0);
      chk_v("rst_out_valid", int'(out_valid), 0);
      chk_v("rst_smm_load", int'(smm_load), 0);
      chk_m("rst_c_mat", c_mat, '0);
      rst = 1'b0;
      @(negedge clk);

      vecs[0].a = ident();        vecs[0].b = count16();      vecs[0].c = count16();    vecs[0].ovf = 1'b0;
      vecs[1].a = fill(DW'(1));   vecs[1].b = fill(DW'(1));   vecs[1].c = fill(DW'(4)); vecs[1].ovf = 1'b0;
      vecs[2].a = fill(DW'(2));   vecs[2].b = fill(DW'(3));   vecs[2].c = fill(DW'(24));vecs[2].ovf = 1'b0;
      vecs[3].a = ident();        vecs[3].b = fill(DW'(7));   vecs[3].c = fill(DW'(7)); vecs[3].ovf = 1'b0;
      vecs[4].a = fill(DW'(32768)); vecs[4].b = fill(DW'(32768));
`ifdef SMM_SAT_ACC_EN
      vecs[4].c = fill(32'h8000_0000); vecs[4].ovf = 1'b1;
`else
      vecs[4].c = fill(32'h0000_0000); vecs[4].ovf = 1'b0;
`endif
      for (int i = 0; i < 5; i++) begin
         run_txn(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].ovf, 0);
         chk_v("load_run_length", last_run, 8);
      end

      // Backpressure: result held 20 cycles while a second request waits.
      out_ready = 1'b0;
      start_txn(fill(DW'(1)), fill(DW'(1)));
      wait_out(lat);
      chk_v("bp_latency", lat, 10);
      a_mat = ident(); b_mat = fill(DW'(5)); in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk_v("bp_out_valid", int'(out_valid), 1);
         chk_m("bp_c_mat", c_mat, fill(DW'(4)));
         chk_v("bp_in_ready", int'(in_ready), 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_v("bp_out_dropped", int'(out_valid), 0);
      chk_v("bp_in_ready_rise", int'(in_ready), 1);
      chk_v("bp_not_yet_busy", int'(busy), 0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk_v("bp_second_accepted", int'(busy), 1);
      wait_out(lat);
      chk_v("bp_second_latency", lat, 10);
      chk_m("bp_second_c", c_mat, fill(DW'(5)));
      accept_out();

      // Reset during the fifth ISSUE cycle.
      out_ready = 1'b1;
      start_txn(count16(), count16());
      repeat (4) begin
         @(posedge clk);
         @(negedge clk);
      end
      chk_v("load_before_rst", int'(smm_load), 1);
      #1 rst = 1'b1;
      #1;
      chk_v("mid_rst_in_ready", int'(in_ready), 1);
      chk_v("mid_rst_smm_load", int'(smm_load), 0);
      chk_m("mid_rst_smm_ab", mat_t'({smm_a, smm_b}), '0);
      chk_v("mid_rst_out_valid", int'(out_valid), 0);
      chk_v("mid_rst_busy", int'(busy), 0);
      chk_m("mid_rst_c_mat", c_mat, '0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_txn(ident(), fill(DW'(7)), fill(DW'(7)), 1'b0, 0);

      // Back-to-back with out_ready high: 12-cycle spacing.
      out_ready = 1'b1;
      start_txn(fill(DW'(2)), fill(DW'(3)));
      wait_out(lat);
      t1 = cyc;
      chk_m("b2b_first_c", c_mat, fill(DW'(24)));
      accept_out();
      start_txn(ident(), count16());
      wait_out(lat);
      t2 = cyc;
      chk_v("b2b_spacing", t2 - t1, 12);
      chk_m("b2b_second_c", c_mat, count16());
      accept_out();

      // Randomized transactions against the matrix-level model.
      for (int t = 0; t < 24; t++) begin
         mode = $urandom_range(0, 1);
         for (int e = 0; e < 16; e++) begin
            ra[e*DW +: DW] = (mode == 0) ? DW'($urandom_range(0, 40)) - DW'(20) : DW'($urandom);
            rb[e*DW +: DW] = (mode == 0) ? DW'($urandom_range(0, 40)) - DW'(20) : DW'($urandom);
         end
         ref_model(ra, rb, rc, rovf);
         run_txn(ra, rb, rc, rovf, $urandom_range(0, 3));
      end

      chk_v("smm_sel_high_count", sel_bad, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
